// File: rtl/hc595_ctrl.sv
// Serial driver for a two-chip 74HC595 chain: packs {dp, seg, sel} into a 16-bit frame and
// shifts it out MSB-first on DS/SHCP, then latches it with STCP. Optional macro: HC595_DP_EN.
module hc595_ctrl #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] sel,
   input  logic [6:0] seg,
`ifdef HC595_DP_EN
   input  logic       dp,
`endif
   output logic       ds,
   output logic       shcp,
   output logic       stcp,
   output logic       oe_n,
   output logic       busy
);

   localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_LATCH = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [15:0]      shadow_q, shadow_d;
   logic             dirty_q, dirty_d;
   logic [15:0]      sreg_q, sreg_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             phase_q, phase_d;
   logic             en_q;
   logic             ds_q, ds_d;
   logic             shcp_q, shcp_d;
   logic             stcp_q, stcp_d;
   logic             oe_n_q, oe_n_d;
   logic             busy_q, busy_d;
   logic             dp_bit_s;
   logic [15:0]      word_s;
   logic             start_s;

`ifdef HC595_DP_EN
   assign dp_bit_s = dp;
`else
   assign dp_bit_s = 1'b1;
`endif

   assign word_s  = {dp_bit_s, seg, sel};
   assign start_s = en && (dirty_q || (word_s != shadow_q));

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shadow_q  <= 16'h0000;
         dirty_q   <= 1'b1;
         sreg_q    <= 16'h0000;
         bit_cnt_q <= 4'd0;
         div_cnt_q <= '0;
         phase_q   <= 1'b0;
         en_q      <= 1'b0;
         ds_q      <= 1'b0;
         shcp_q    <= 1'b0;
         stcp_q    <= 1'b0;
         oe_n_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         dirty_q   <= dirty_d;
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         phase_q   <= phase_d;
         en_q      <= en;
         ds_q      <= ds_d;
         shcp_q    <= shcp_d;
         stcp_q    <= stcp_d;
         oe_n_q    <= oe_n_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic; outputs are derived from the next state so the pins stay registered
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      dirty_d   = dirty_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;

      if (en && !en_q) begin
         dirty_d = 1'b1;
      end else begin
         dirty_d = dirty_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_d   = ST_SHIFT;
            sreg_d    = word_s;
            shadow_d  = word_s;
            dirty_d   = 1'b0;
            bit_cnt_d = 4'd0;
            div_cnt_d = '0;
            phase_d   = 1'b0;
         end
         ST_SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d   = 1'b0;
                  sreg_d    = {sreg_q[14:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd15) begin
                     state_d = ST_LATCH;
                  end else begin
                     state_d = ST_SHIFT;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         ST_LATCH: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d == ST_SHIFT) begin
         ds_d = sreg_d[15];
      end else begin
         ds_d = 1'b0;
      end
      shcp_d = (state_d == ST_SHIFT) && phase_d;
      stcp_d = (state_d == ST_LATCH);
      busy_d = (state_d != ST_IDLE);

      // Output enable drops after a completed latch, and only while the display is enabled
      if (!en) begin
         oe_n_d = 1'b1;
      end else if ((state_q == ST_LATCH) && (div_cnt_q == DIV_LAST)) begin
         oe_n_d = 1'b0;
      end else begin
         oe_n_d = oe_n_q;
      end
   end

   assign ds   = ds_q;
   assign shcp = shcp_q;
   assign stcp = stcp_q;
   assign oe_n = oe_n_q;
   assign busy = busy_q;

endmodule
